// File: rtl/spi_slave_cu.sv
// spi_slave_cu: SPI responder control unit and datapath.
// SCK, SS_n and MOSI are oversampled in the Clk domain. All four CPol/CPha modes
// are decoded. One DATA_W word is shifted out on MISO while one is shifted in
// from MOSI. The host side has a one-entry TX holding register (valid/ready) and
// an RX word with a one-cycle strobe.
// Build option: define SPI_SLV_LSB_FIRST_EN to move bit 0 first on the wire.
// When it is undefined, the MSB goes first. The port list is the same in both builds.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | no frame; waiting for a synced SS_n fall
// LOAD  | one cycle: copy holding register (or zeros) into the TX shifter
// SHIFT | sampling MOSI / shifting MISO on decoded SCK edges

module spi_slave_cu #(
    parameter int DATA_W      = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic              Clk,
    input  logic              Rst_n,
    input  logic              CPol,
    input  logic              CPha,
    input  logic              SCK,
    input  logic              SS_n,
    input  logic              MOSI,
    output logic              MISO,
    output logic              MISO_oe,
    input  logic [DATA_W-1:0] TxData,
    input  logic              TxValid,
    output logic              TxReady,
    output logic [DATA_W-1:0] RxData,
    output logic              RxValid,
    output logic              Busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2
    } state_t;

    localparam int              CNT_W    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

    // synchronizers
    logic [SYNC_STAGES-1:0] sck_sync;
    logic [SYNC_STAGES-1:0] ss_sync;
    logic [SYNC_STAGES-1:0] mosi_sync;
    logic                   sck_s;
    logic                   ss_s;
    logic                   mosi_s;

    // edge detection
    logic sck_prev;
    logic ss_prev;
    logic sck_rise;
    logic sck_fall;
    logic lead_edge;
    logic trail_edge;
    logic sample_edge;
    logic shift_edge;
    logic ss_fall;
    logic sample_p;
    logic shift_p;
    logic mosi_p;

    // control
    state_t           state;
    state_t           state_nxt;
    logic             load_en;
    logic             word_done;
    logic             drop_word;
    logic             sample_en;
    logic             shift_en;
    logic [CNT_W-1:0] bit_cnt;

    // datapath
    logic [DATA_W-1:0] hold_data;
    logic              hold_full;
    logic [DATA_W-1:0] tx_shift;
    logic [DATA_W-1:0] rx_shift;
    logic [DATA_W-1:0] rx_next;
    logic              tx_bit;

    assign sck_s  = sck_sync[SYNC_STAGES-1];
    assign ss_s   = ss_sync[SYNC_STAGES-1];
    assign mosi_s = mosi_sync[SYNC_STAGES-1];

    // Bring the three asynchronous pins into the Clk domain.
    // SS_n resets to deselected so that no spurious frame starts.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            sck_sync  <= '0;
            ss_sync   <= '1;
            mosi_sync <= '0;
        end else begin
            sck_sync  <= {sck_sync[SYNC_STAGES-2:0], SCK};
            ss_sync   <= {ss_sync[SYNC_STAGES-2:0], SS_n};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], MOSI};
        end
    end

    assign sck_rise    = sck_s & ~sck_prev;
    assign sck_fall    = ~sck_s & sck_prev;
    // Leading edge means SCK leaves its idle level. Trailing edge means it returns to it.
    assign lead_edge   = CPol ? sck_fall : sck_rise;
    assign trail_edge  = CPol ? sck_rise : sck_fall;
    assign sample_edge = CPha ? trail_edge : lead_edge;
    assign shift_edge  = CPha ? lead_edge : trail_edge;
    assign ss_fall     = ss_prev & ~ss_s;

    // Keep the previous synced levels for edge detection, and register the decoded strobes.
    // MOSI and SS_n are delayed by the same amount, so a final sample and an SS_n rise
    // that arrive together are seen in the same cycle.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            sck_prev <= 1'b0;
            ss_prev  <= 1'b1;
            sample_p <= 1'b0;
            shift_p  <= 1'b0;
            mosi_p   <= 1'b0;
        end else begin
            sck_prev <= sck_s;
            ss_prev  <= ss_s;
            sample_p <= sample_edge;
            shift_p  <= shift_edge;
            mosi_p   <= mosi_s;
        end
    end

    // FSM state register
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and per-cycle control strobes.
    // A completing word takes priority over an SS_n rise in the same cycle.
    always_comb begin
        state_nxt = state;
        load_en   = 1'b0;
        word_done = 1'b0;
        drop_word = 1'b0;
        sample_en = 1'b0;
        shift_en  = 1'b0;
        case (state)
            IDLE: begin
                if (ss_fall) begin
                    state_nxt = LOAD;
                end
            end
            LOAD: begin
                if (ss_prev) begin
                    drop_word = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    load_en   = 1'b1;
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                if (sample_p && (bit_cnt == LAST_BIT)) begin
                    word_done = 1'b1;
                    state_nxt = ss_prev ? IDLE : LOAD;
                end else if (ss_prev) begin
                    drop_word = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    sample_en = sample_p;
                    // A shift edge that comes before the first sample of a word is ignored.
                    // In CPha=1 this is the first leading edge. In CPha=0 it is the trailing
                    // edge left over from the previous word.
                    shift_en  = shift_p && (bit_cnt != '0);
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

`ifdef SPI_SLV_LSB_FIRST_EN
    assign rx_next = {mosi_p, rx_shift[DATA_W-1:1]};
    assign tx_bit  = tx_shift[0];
`else
    assign rx_next = {rx_shift[DATA_W-2:0], mosi_p};
    assign tx_bit  = tx_shift[DATA_W-1];
`endif

    // Bit counter: counts sample edges within a word. It wraps on completion and clears on abort.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            bit_cnt <= '0;
        end else if (word_done || drop_word) begin
            bit_cnt <= '0;
        end else if (sample_en) begin
            bit_cnt <= bit_cnt + CNT_W'(1);
        end
    end

    // One-entry TX holding register.
    // A host load in the same cycle as a LOAD copy (of an empty register) is kept for the next word.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            hold_data <= '0;
            hold_full <= 1'b0;
        end else if (TxValid && !hold_full) begin
            hold_data <= TxData;
            hold_full <= 1'b1;
        end else if (load_en) begin
            hold_full <= 1'b0;
        end
    end

    // TX shift register: loaded in LOAD (zeros on underrun), advanced on shift edges
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            tx_shift <= '0;
        end else if (load_en) begin
            tx_shift <= hold_full ? hold_data : '0;
        end else if (shift_en) begin
`ifdef SPI_SLV_LSB_FIRST_EN
            tx_shift <= {1'b0, tx_shift[DATA_W-1:1]};
`else
            tx_shift <= {tx_shift[DATA_W-2:0], 1'b0};
`endif
        end
    end

    // RX shift register: collects MOSI on sample edges. A partial word is discarded on abort.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            rx_shift <= '0;
        end else if (drop_word) begin
            rx_shift <= '0;
        end else if (sample_en || word_done) begin
            rx_shift <= rx_next;
        end
    end

    // RX output word and its one-cycle strobe
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            RxData  <= '0;
            RxValid <= 1'b0;
        end else begin
            RxValid <= word_done;
            if (word_done) begin
                RxData <= rx_next;
            end
        end
    end

    assign MISO_oe = ~ss_s;
    assign MISO    = MISO_oe & (state == SHIFT) & tx_bit;
    assign TxReady = ~hold_full;
    assign Busy    = (state != IDLE);

endmodule
